pipe_stage_buf: RTL
===================

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- DATA_W, 32, payload width in bits (1..256).
- CTRL_W, 16, control-field width in bits (1..64).
- DEPTH, 2, number of entries (1..8, need not be a power of two).
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous kill of all held entries.
- in_valid  input  1  upstream offers an entry.
- in_ready  output  1  block can accept an entry.
- in_ctrl  input  CTRL_W  control bits (enables, command, dest, status).
- in_data  input  DATA_W  operand payload (pc, operand values).
- out_valid  output  1  head entry present.
- out_ready  input  1  downstream takes the head entry.
- out_ctrl  output  CTRL_W  head control bits.
- out_data  output  DATA_W  head payload.
- count  output  CNT_W  current occupancy.

Function
REQ-003 The block SHALL be a FIFO of DEPTH entries, each holding {ctrl, data}, delivered in arrival order.
REQ-004 Push SHALL occur when in_valid=1, in_ready=1 and flush=0; the entry is visible on out_* from the next cycle at the earliest (latency 1).
REQ-005 in_ready SHALL be count<DEPTH, decoded from registered state only, with no combinational path from out_ready or in_valid.
REQ-006 Pop SHALL occur when out_valid=1, out_ready=1 and flush=0.
REQ-007 out_valid SHALL be count!=0; out_ctrl and out_data SHALL show the head entry, and SHALL be all-zero when count=0.
REQ-008 Simultaneous push and pop with 0<count<DEPTH SHALL leave count unchanged and advance both pointers.
REQ-009 At count=DEPTH, a pop SHALL NOT enable a push in the same cycle, because in_ready=0.
REQ-010 Write and read pointers SHALL wrap from DEPTH-1 to 0.
REQ-011 count SHALL be the number of valid entries, and SHALL never exceed DEPTH or underflow.
REQ-012 flush=1 SHALL have priority over push and pop: next cycle count=0, pointers=0, out_valid=0, out_ctrl=0, out_data=0; a push offered in the flush cycle is discarded.
REQ-013 Storage contents SHALL NOT be observable while empty: zeroing on empty is required on out_*, while stale RAM contents are permitted internally.
REQ-014 X on in_ctrl or in_data SHALL NOT propagate to out_* unless the entry was pushed.

Reset
REQ-015 While rst=1, independent of clk, the block SHALL drive count=0, pointers=0, out_valid=0, out_ctrl=0, out_data=0 and in_ready=1.
REQ-016 rst asserted mid-operation SHALL discard all entries immediately.
REQ-017 After rst deasserts, the first rising edge SHALL accept a push.

Verification
REQ-018 The bench SHALL cover these directed scenarios (DEPTH=2, DATA_W=32, CTRL_W=16):
- Reset, then push ctrl=0x00A5 data=0x12345678 with out_ready=0 -> next cycle out_valid=1, out_ctrl=0x00A5, out_data=0x12345678, count=1.
- Push 3 entries back-to-back (D1, D2, D3) with out_ready=0 -> count=2 after 2 cycles, in_ready=0, D3 held off; set out_ready=1 -> pops D1, D2, D3 in order.
- Steady push and pop every cycle for 10 entries with count=1 -> count stays 1, output order equals input order, pointers wrap through 0.
- Full (count=2), flush=1 together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_ctrl=0, out_data=0, pushed entry absent.
- rst pulsed mid-cycle while count=2 -> out_valid=0 and count=0 before the next clk edge; push after release works.
- DEPTH=3 build: 7 push/pop rounds -> pointers wrap at 2 to 0, no loss or duplication.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Pipeline stage buffer: DEPTH-entry FIFO of {ctrl, data} with synchronous flush; latency 1.
// in_ready comes from registered occupancy only, so a pop cannot free a slot for a push in the same cycle.
module pipe_stage_buf #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENT_W = CTRL_W + DATA_W;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  logic [ENT_W-1:0] head;

  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // Gate the head with occupancy so stale storage never leaks onto out_*.
  assign head     = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_ctrl = head[ENT_W-1:DATA_W];
  assign out_data = head[DATA_W-1:0];

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = {in_ctrl, in_data};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; unoccupied slots are masked at the output.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
